// File: rtl/vtg_pattern_gen.sv
// Parametrised video timing generator with eight test patterns and frame-aligned mode switching.
// All outputs are registered one cycle after the counter state they describe.
module vtg_pattern_gen #(
    parameter int H_TOTAL         = 1650,
    parameter int H_SYNC          = 40,
    parameter int H_BPORCH        = 220,
    parameter int H_RES           = 1280,
    parameter int V_TOTAL         = 750,
    parameter int V_SYNC          = 5,
    parameter int V_BPORCH        = 20,
    parameter int V_RES           = 720,
    parameter bit HS_POL          = 1'b1,
    parameter bit VS_POL          = 1'b1,
    parameter int FRAMES_PER_MODE = 256,
    parameter int CW              = 12
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst_n,
    input  logic [2:0] I_mode,
    input  logic       I_auto_en,
    input  logic [7:0] I_single_r,
    input  logic [7:0] I_single_g,
    input  logic [7:0] I_single_b,
    output logic       O_de,
    output logic       O_hs,
    output logic       O_vs,
    output logic [7:0] O_data_r,
    output logic [7:0] O_data_g,
    output logic [7:0] O_data_b,
    output logic       O_frame_start,
    output logic [2:0] O_mode_active
);

    localparam int BAR_W = ((H_RES >> 3) > 0) ? (H_RES >> 3) : 1;
    localparam int AW    = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_A0     = CW'(H_SYNC + H_BPORCH);
    localparam logic [CW-1:0] H_A1     = CW'(H_SYNC + H_BPORCH + H_RES);
    localparam logic [CW-1:0] V_A0     = CW'(V_SYNC + V_BPORCH);
    localparam logic [CW-1:0] V_A1     = CW'(V_SYNC + V_BPORCH + V_RES);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(FRAMES_PER_MODE - 1);

    logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d, barc_q, barc_d;
    logic [2:0]    bar_q, bar_d, cur_mode_q, cur_mode_d, auto_mode_q, auto_mode_d;
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic [7:0]    frame_q, frame_d;
    logic          h_wrap, v_wrap, frame_end, hs_int, vs_int, h_act, v_act, de_int;
    logic [7:0]    r_d, g_d, b_d;

    always_comb begin
        h_wrap    = (h_q == H_LAST);
        v_wrap    = (v_q == V_LAST);
        frame_end = h_wrap & v_wrap;
        hs_int    = (h_q < CW'(H_SYNC));
        vs_int    = (v_q < CW'(V_SYNC));
        h_act     = (h_q >= H_A0) && (h_q < H_A1);
        v_act     = (v_q >= V_A0) && (v_q < V_A1);
        de_int    = h_act & v_act;

        h_d = h_wrap ? '0 : h_q + CW'(1);
        v_d = v_q;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + CW'(1);

        x_d = h_act ? x_q + CW'(1) : '0;

        // Bar index saturates at 7 so any remainder pixels extend the last bar.
        bar_d  = '0;
        barc_d = '0;
        if (h_act) begin
            if (barc_q == BAR_LAST && bar_q != 3'd7) begin
                bar_d  = bar_q + 3'd1;
                barc_d = '0;
            end else begin
                bar_d  = bar_q;
                barc_d = barc_q + CW'(1);
            end
        end

        y_d = y_q;
        if (h_wrap) begin
            if (v_wrap)     y_d = '0;
            else if (v_act) y_d = y_q + CW'(1);
        end

        frame_d     = frame_q;
        auto_cnt_d  = auto_cnt_q;
        auto_mode_d = auto_mode_q;
        cur_mode_d  = cur_mode_q;
        if (frame_end) begin
            frame_d = frame_q + 8'd1;
            if (auto_cnt_q == AUTO_LAST) begin
                auto_cnt_d  = '0;
                auto_mode_d = (auto_mode_q == 3'd5) ? 3'd0 : auto_mode_q + 3'd1;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
            // The new frame shows the auto mode that is current after this boundary's advance.
            cur_mode_d = I_auto_en ? auto_mode_d : I_mode;
        end

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_int) begin
            case (cur_mode_q)
                3'd0: begin
                    r_d = {8{~bar_q[1]}};
                    g_d = {8{~bar_q[2]}};
                    b_d = {8{~bar_q[0]}};
                end
                3'd1: if (x_q[4:0] == 5'd0 || y_q[4:0] == 5'd0) {r_d, g_d, b_d} = '1;
                3'd2: {r_d, g_d, b_d} = {3{x_q[7:0]}};
                3'd3: {r_d, g_d, b_d} = {I_single_r, I_single_g, I_single_b};
                3'd4: if (x_q[5] ^ y_q[5]) {r_d, g_d, b_d} = '1;
                3'd5: {r_d, g_d, b_d} = {3{y_q[7:0]}};
                3'd6: begin
                    r_d = frame_q;
                    g_d = ~frame_q;
                end
                default: r_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            barc_q        <= '0;
            bar_q         <= '0;
            frame_q       <= '0;
            auto_cnt_q    <= '0;
            auto_mode_q   <= '0;
            cur_mode_q    <= '0;
            O_de          <= 1'b0;
            O_hs          <= ~HS_POL;
            O_vs          <= ~VS_POL;
            O_data_r      <= '0;
            O_data_g      <= '0;
            O_data_b      <= '0;
            O_frame_start <= 1'b0;
            O_mode_active <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            barc_q        <= barc_d;
            bar_q         <= bar_d;
            frame_q       <= frame_d;
            auto_cnt_q    <= auto_cnt_d;
            auto_mode_q   <= auto_mode_d;
            cur_mode_q    <= cur_mode_d;
            O_de          <= de_int;
            O_hs          <= ~(hs_int ^ HS_POL);
            O_vs          <= ~(vs_int ^ VS_POL);
            O_data_r      <= r_d;
            O_data_g      <= g_d;
            O_data_b      <= b_d;
            O_frame_start <= (h_q == '0) && (v_q == '0);
            O_mode_active <= cur_mode_q;
        end
    end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Randomised bench for vtg_pattern_gen; expectations come from an arithmetic model of the
// raster (cycle index -> line/pixel/frame) rather than from counters.
module tb_vtg_pattern_gen;

    localparam int H_TOTAL  = 20;
    localparam int H_SYNC   = 2;
    localparam int H_BPORCH = 2;
    localparam int H_RES    = 16;
    localparam int V_TOTAL  = 10;
    localparam int V_SYNC   = 1;
    localparam int V_BPORCH = 2;
    localparam int V_RES    = 4;
    localparam int FPM      = 2;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int BAR_W    = H_RES / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic       auto_en;
    logic [7:0] sr, sg, sb;
    logic       de, hs, vs, fs;
    logic [7:0] dr, dg, db;
    logic [2:0] mode_act;

    int t;
    int cur_m;
    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vtg_pattern_gen #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BPORCH(H_BPORCH), .H_RES(H_RES),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BPORCH(V_BPORCH), .V_RES(V_RES),
        .HS_POL(1'b1), .VS_POL(1'b1), .FRAMES_PER_MODE(FPM), .CW(12)
    ) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode(mode), .I_auto_en(auto_en),
        .I_single_r(sr), .I_single_g(sg), .I_single_b(sb),
        .O_de(de), .O_hs(hs), .O_vs(vs),
        .O_data_r(dr), .O_data_g(dg), .O_data_b(db),
        .O_frame_start(fs), .O_mode_active(mode_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_de",   32'(de), 32'd0);
        check("rst_hs",   32'(hs), 32'd0);
        check("rst_vs",   32'(vs), 32'd0);
        check("rst_rgb",  32'({dr, dg, db}), 32'd0);
        check("rst_fs",   32'(fs), 32'd0);
        check("rst_mode", 32'(mode_act), 32'd0);
    endtask

    // Releases reset 1 time unit after a rising edge; the next edge is the first counting one.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t     = 0;
        cur_m = 0;
    endtask

    task automatic step();
        int h, v, f, x, y, bar;
        logic e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        h = t % H_TOTAL;
        v = (t / H_TOTAL) % V_TOTAL;
        f = t / FRAME;
        x = h - (H_SYNC + H_BPORCH);
        y = v - (V_SYNC + V_BPORCH);
        e_de = (x >= 0) && (x < H_RES) && (y >= 0) && (y < V_RES);
        e_hs = (h < H_SYNC);
        e_vs = (v < V_SYNC);
        e_fs = (h == 0) && (v == 0);
        e_rgb = 24'h0;
        if (e_de) begin
            bar = (x / BAR_W > 7) ? 7 : x / BAR_W;
            case (cur_m)
                0: e_rgb = bar_rgb[bar];
                1: e_rgb = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h0;
                2: e_rgb = {3{8'(x % 256)}};
                3: e_rgb = {sr, sg, sb};
                4: e_rgb = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
                5: e_rgb = {3{8'(y % 256)}};
                6: e_rgb = {8'(f % 256), 8'(255 - f % 256), 8'h00};
                default: e_rgb = 24'hFF0000;
            endcase
        end
        @(posedge clk);
        #1;
        check("de",   32'(de), 32'(e_de));
        check("hs",   32'(hs), 32'(e_hs));
        check("vs",   32'(vs), 32'(e_vs));
        check("fs",   32'(fs), 32'(e_fs));
        check("rgb",  32'({dr, dg, db}), 32'(e_rgb));
        check("mode", 32'(mode_act), 32'(cur_m));
        if (h == H_TOTAL - 1 && v == V_TOTAL - 1)
            cur_m = auto_en ? (((f + 1) / FPM) % 6) : int'(mode);
        t++;
    endtask

    task automatic rand_single();
        sr = 8'($urandom);
        sg = 8'($urandom);
        sb = 8'($urandom);
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 3'd0;
        auto_en = 1'b0;
        sr = 8'h0; sg = 8'h0; sb = 8'h0;
        t = 0;
        cur_m = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        release_reset();

        // Colour bars for two frames.
        for (int i = 0; i < 2 * FRAME; i++) begin
            rand_single();
            step();
        end

        // Manual modes changed mid-frame; first change is 0->4 at cycle 50.
        for (int fr = 0; fr < 16; fr++) begin
            int chg;
            chg = (fr == 0) ? 50 : int'($urandom_range(1, FRAME - 2));
            for (int c = 0; c < FRAME; c++) begin
                if (c == chg) begin
                    mode    = (fr == 0) ? 3'd4 : 3'($urandom);
                    auto_en = (fr >= 2) && ($urandom_range(0, 3) == 0);
                end
                rand_single();
                step();
            end
        end

        // Asynchronous reset asserted mid-active-line (line 4, pixel 10).
        mode    = 3'd7;
        auto_en = 1'b0;
        while (!((t % H_TOTAL) == 10 && ((t / H_TOTAL) % V_TOTAL) == 4)) step();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        release_reset();
        for (int i = 0; i < FRAME; i++) begin
            rand_single();
            step();
        end

        // Auto-cycling from reset; I_mode wiggles and must be ignored.
        #2;
        rst_n   = 1'b0;
        auto_en = 1'b1;
        #1;
        check_reset_state();
        release_reset();
        for (int i = 0; i < 13 * FRAME; i++) begin
            mode = 3'($urandom);
            rand_single();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
